uart_receiver: RTL
==================

Name: uart_receiver

Overview:
- Serial-to-parallel receiver pairing with the existing UART transmitter.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (parity bit = XOR of data bits), 1 stop bit (1).
- Uses the shared baud_controller for a 16x oversampling tick. Presents the received byte with valid and error flags to the host logic.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit; must match baud_controller; only 16 is supported.
- SYNC_STAGES, 2, flip-flop stages on RxD before use.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- baud_select  in  3  rate select, passed to baud_controller; same encoding as the transmitter
- Rx_EN  in  1  receiver enable; 0 holds the FSM in IDLE
- RxD  in  1  serial input, asynchronous to clock, idle high
- Rx_DATA  out  8  last received byte
- Rx_VALID  out  1  one-clock pulse: good frame received
- Rx_PERROR  out  1  parity error on last frame
- Rx_FERROR  out  1  framing error (stop bit sampled 0) on last frame
- Rx_BUSY  out  1  frame in progress

Behaviour:
- Clocking and timing
  - Single clock domain: everything is clocked on posedge clock.
  - The baud_controller output Rx_sample_ENABLE is a one-clock clock-enable, never a clock.
  - RxD passes through SYNC_STAGES flops to give rxd_s; the FSM uses only rxd_s.
- Reset (reset=0, asynchronous)
  - state=IDLE, tick counter=0, bit index=0.
  - Rx_DATA=0, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, Rx_BUSY=0.
  - Synchronizer flops reset to 1.
- Tick counter
  - 4 bits; advances only on a sample tick; wraps 15->0.
  - Cleared on every state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur on sample ticks.
  - IDLE: if Rx_EN=1 and rxd_s=0 on a tick -> START, counter=0.
  - START:
    - At counter=7 (mid start bit), rxd_s=1 -> false start -> IDLE, no flags changed.
    - At counter=7, rxd_s=0 -> DATA, counter=0, bit index=0.
  - DATA:
    - At counter=15 (mid data bit), shift rxd_s into shift register bit [index]; index+1.
    - After index 7 is captured -> PARITY.
  - PARITY: at counter=15, capture the parity bit -> STOP.
  - STOP: at counter=15, sample the stop bit, then:
    - Rx_DATA <= shift register (updated even when errors are present).
    - Rx_PERROR <= (XOR of data) XOR parity bit.
    - Rx_FERROR <= ~rxd_s.
    - Rx_VALID pulses for exactly 1 clock iff both errors are 0.
    - -> IDLE.
- Output behaviour
  - The error flags hold until the next completed frame overwrites them.
  - Rx_BUSY=1 in START/DATA/PARITY/STOP; Rx_BUSY=0 in IDLE.
- Latency: Rx_VALID rises 1 clock after the tick at the stop-bit midpoint (about 10.5 bit times after the falling start edge).
- Back-to-back frames: returning to IDLE at the stop-bit midpoint allows a start edge immediately after the stop bit to be caught.
- Rx_EN deasserted mid-frame: abort to IDLE on the next clock. No Rx_VALID, flags unchanged, Rx_DATA unchanged.
- Reset mid-frame: immediate return to the reset state; the partial byte is discarded.
- Line held low continuously (break): produces one frame with Rx_FERROR=1. IDLE then re-triggers only after rxd_s has been seen as 1 for at least one tick.
- baud_select changes mid-frame: not supported; the frame result is undefined. Recovery occurs by the next idle line.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3 bits), common with the transmitter;
  - OVERSAMPLE=16, MID_SAMPLE=7, LAST_TICK=15, DATA_BITS=8;
  - the baud_select rate table.
- Sub-module: baud_controller (existing, instantiated unchanged). Synchronizer stays inline.

Test Plan:
- Clean frame: baud_select=3'b111, send 0xA5 with parity 0 and stop 1 -> Rx_DATA=8'hA5, one-clock Rx_VALID, PERROR=0, FERROR=0, Rx_BUSY low after the stop-bit midpoint.
- Parity error: send 0x3C with parity 1 -> Rx_DATA=8'h3C, Rx_PERROR=1, Rx_VALID stays 0. Then send 0x3C with parity 0 -> PERROR clears, VALID pulses.
- Framing error: send 0x81 with stop bit 0 -> Rx_FERROR=1, Rx_VALID=0. Line then idle high; next good frame 0x55 -> FERROR=0, VALID=1.
- False start: RxD low for 4 ticks, then high -> FSM returns to IDLE, Rx_BUSY pulses only during START, no VALID, Rx_DATA unchanged.
- Back-to-back: frames 0x00, 0xFF with zero idle gap at baud_select=3'b011 -> two VALID pulses, data 8'h00 then 8'hFF, no errors.
- Abort and reset: deassert Rx_EN during DATA bit 3 -> IDLE, no VALID. Repeat and pull reset low in PARITY -> all outputs 0 immediately (asynchronous, mid-cycle); subsequent 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing constants and the baud rate table.
// The transmitter and receiver both import this package so that their encodings stay in step.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;
   localparam int LAST_TICK  = 15;
   localparam int DATA_BITS  = 8;
   localparam int BAUD_DIV_W = 16;

   // Terminal count (clocks per sample tick minus one) for each baud_select code.
   function automatic logic [BAUD_DIV_W-1:0] baud_last(input logic [2:0] sel);
      case (sel)
         3'd0:    return 16'd383;
         3'd1:    return 16'd191;
         3'd2:    return 16'd95;
         3'd3:    return 16'd47;
         3'd4:    return 16'd23;
         3'd5:    return 16'd11;
         3'd6:    return 16'd5;
         default: return 16'd2;
      endcase
   endfunction

endpackage

// File: rtl/baud_controller.sv
// Free-running divider producing a one-clock Rx_sample_ENABLE at 16x the selected baud rate.
// The enable is a registered clock-enable; it is never used as a clock.
module baud_controller
   import uart_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] baud_select,
   output logic       Rx_sample_ENABLE
);

   logic [BAUD_DIV_W-1:0] div_cnt;
   logic [BAUD_DIV_W-1:0] div_last;

   assign div_last = baud_last(baud_select);

   // >= rather than == so a rate change to a shorter period cannot strand the counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_cnt          <= '0;
         Rx_sample_ENABLE <= 1'b0;
      end else if (div_cnt >= div_last) begin
         div_cnt          <= '0;
         Rx_sample_ENABLE <= 1'b1;
      end else begin
         div_cnt          <= div_cnt + BAUD_DIV_W'(1);
         Rx_sample_ENABLE <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8E1 UART receiver with 16x oversampling; Rx_VALID pulses one clock after the stop-bit mid-sample tick.
// Result byte and error flags are held until the next completed frame overwrites them.
module uart_receiver #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR,
   output logic       Rx_BUSY
);
   import uart_pkg::*;

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS);

   uart_state_t            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   par_q, par_d;
   logic                   armed_q, armed_d;
   logic [7:0]             data_d;
   logic                   perr_d, ferr_d, valid_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   logic                   tick;

   baud_controller u_baud (
      .clock            (clock),
      .reset            (reset),
      .baud_select      (baud_select),
      .Rx_sample_ENABLE (tick)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
   end
   assign rxd_s = sync_q[SYNC_STAGES-1];

   assign Rx_BUSY = (state_q != IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         armed_q   <= 1'b1;
         Rx_DATA   <= '0;
         Rx_VALID  <= 1'b0;
         Rx_PERROR <= 1'b0;
         Rx_FERROR <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         armed_q   <= armed_d;
         Rx_DATA   <= data_d;
         Rx_VALID  <= valid_d;
         Rx_PERROR <= perr_d;
         Rx_FERROR <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      armed_d = armed_q;
      data_d  = Rx_DATA;
      perr_d  = Rx_PERROR;
      ferr_d  = Rx_FERROR;
      valid_d = 1'b0;

      // armed drops after a low stop bit so a held-low line (break) yields a single frame.
      if (tick && rxd_s) armed_d = 1'b1;

      if (!Rx_EN) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else if (tick) begin
         case (state_q)
            IDLE: begin
               if (!rxd_s && armed_q) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               if (cnt_q == CNT_W'(MID_SAMPLE)) begin
                  state_d = rxd_s ? IDLE : DATA;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt_q == CNT_W'(LAST_TICK)) begin
                  shreg_d[idx_q] = rxd_s;
                  if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                     state_d = PARITY;
                     cnt_d   = '0;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PARITY: begin
               if (cnt_q == CNT_W'(LAST_TICK)) begin
                  par_d   = rxd_s;
                  state_d = STOP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt_q == CNT_W'(LAST_TICK)) begin
                  data_d  = shreg_q;
                  perr_d  = (^shreg_q) ^ par_q;
                  ferr_d  = ~rxd_s;
                  valid_d = ~perr_d & rxd_s;
                  if (!rxd_s) armed_d = 1'b0;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule
